mux8x3_core: RTL and testbench

MUX8X3_CORE -- requirements
Module: mux8x3

---
 rtl/mux8x3_core_if.sv | 22 ++
 rtl/mux8x3_core.sv | 67 ++++++
 tb/tb_mux8x3_core.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mux8x3_core_if.sv
// Signal bundle for the reversed 8:1 selector: data candidates, select/valid
// qualifiers and both output views. Benches and neighbouring blocks wire through it.
interface mux8x3_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]       select;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_valid;

    modport master (
        output a, b, c, d, e, f, g, h, select, in_valid,
        input  out, out_q, out_valid
    );

    modport slave (
        input  a, b, c, d, e, f, g, h, select, in_valid,
        output out, out_q, out_valid
    );
endinterface

// File: rtl/mux8x3_core.sv
// Reversed-map 8:1 selector (000->h ... 111->a) with an optional one-cycle
// registered copy, compiled in when MUX8X3_REG_OUT_EN is defined.
module mux8x3_core #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       select,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);
    logic [WIDTH-1:0] w_sel;

    // An X/Z select matches no item and falls to the zero default.
    always_comb begin
        w_sel = '0;
        case (select)
            3'b000:  w_sel = h;
            3'b001:  w_sel = g;
            3'b010:  w_sel = f;
            3'b011:  w_sel = e;
            3'b100:  w_sel = d;
            3'b101:  w_sel = c;
            3'b110:  w_sel = b;
            3'b111:  w_sel = a;
            default: w_sel = '0;
        endcase
    end

    assign out = w_sel;

`ifdef MUX8X3_REG_OUT_EN
    logic [WIDTH-1:0] r_q;
    logic             r_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid)
                r_q <= w_sel;
        end
    end

    assign out_q     = r_q;
    assign out_valid = r_vld;
`else
    logic w_unused;

    // Without the register stage the clock and reset have no load.
    assign w_unused  = clk ^ rst_n;
    assign out_q     = w_sel;
    assign out_valid = in_valid;
`endif
endmodule

// File: tb/tb_mux8x3_core.sv
// Directed bench for mux8x3_core (WIDTH=8): reversed select map, sweep,
// and either the registered path or the pass-through build.
module tb_mux8x3_core;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    mux8x3_if #(.WIDTH(8)) bus ();

    mux8x3_core #(.WIDTH(8)) dut (
        .out       (bus.out),
        .a         (bus.a),
        .b         (bus.b),
        .c         (bus.c),
        .d         (bus.d),
        .e         (bus.e),
        .f         (bus.f),
        .g         (bus.g),
        .h         (bus.h),
        .select    (bus.select),
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .out_q     (bus.out_q),
        .out_valid (bus.out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary by time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ah packs a in the top byte down to h in the bottom byte.
    task automatic drive(input logic [63:0] ah, input logic [2:0] s, input logic iv);
        bus.a        = ah[63:56];
        bus.b        = ah[55:48];
        bus.c        = ah[47:40];
        bus.d        = ah[39:32];
        bus.e        = ah[31:24];
        bus.f        = ah[23:16];
        bus.g        = ah[15:8];
        bus.h        = ah[7:0];
        bus.select   = s;
        bus.in_valid = iv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(64'h0, 3'd0, 1'b0);
        @(negedge clk);
        tick();
        chk("reset out", bus.out, 8'h00);
`ifdef MUX8X3_REG_OUT_EN
        chk("reset out_q", bus.out_q, 8'h00);
        chk("reset out_valid", {7'b0, bus.out_valid}, 8'h00);
`else
        chk("pt reset out_q", bus.out_q, 8'h00);
        chk("pt reset out_valid", {7'b0, bus.out_valid}, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single-hot directed vectors
        drive(64'h0000_0000_0000_0001, 3'b000, 1'b0); #1;
        chk("h sel000", bus.out, 8'h01);
        drive(64'h0000_0000_0000_0100, 3'b001, 1'b0); #1;
        chk("g sel001", bus.out, 8'h01);
        drive(64'h0000_0000_0000_0100, 3'b000, 1'b0); #1;
        chk("g only sel000", bus.out, 8'h00);
        drive(64'h0000_0001_0000_0000, 3'b100, 1'b0); #1;
        chk("d sel100", bus.out, 8'h01);
        drive(64'h0000_0000_0001_0000, 3'b010, 1'b0); #1;
        chk("f sel010", bus.out, 8'h01);
        drive(64'h0100_0001_0000_0000, 3'b111, 1'b0); #1;
        chk("a+d sel111", bus.out, 8'h01);
        drive(64'h0000_0001_0000_0000, 3'b111, 1'b0); #1;
        chk("d only sel111", bus.out, 8'h00);

        // Sweep: a..h = A0..A7, select i picks A7-i
        for (int i = 0; i < 8; i++) begin
            drive(64'hA0A1_A2A3_A4A5_A6A7, i[2:0], 1'b0); #1;
            chk($sformatf("sweep sel%0d", i), bus.out, 8'hA7 - 8'(i));
        end

`ifdef MUX8X3_REG_OUT_EN
        @(negedge clk);
        drive(64'h0000_0000_0100_0000, 3'b011, 1'b1);
        tick();
        chk("capture e out_q", bus.out_q, 8'h01);
        chk("capture e out_valid", {7'b0, bus.out_valid}, 8'h01);
        @(negedge clk);
        drive(64'h0000_0000_0000_0000, 3'b011, 1'b0);
        tick();
        chk("hold out_q", bus.out_q, 8'h01);
        chk("hold out_valid", {7'b0, bus.out_valid}, 8'h00);

        // Back-to-back valid cycles, one update per edge
        @(negedge clk);
        drive(64'hA0A1_A2A3_A4A5_A6A7, 3'b000, 1'b1);
        tick();
        chk("b2b0 out_q", bus.out_q, 8'hA7);
        @(negedge clk);
        drive(64'hA0A1_A2A3_A4A5_A6A7, 3'b101, 1'b1);
        tick();
        chk("b2b1 out_q", bus.out_q, 8'hA2);
        chk("b2b1 out_valid", {7'b0, bus.out_valid}, 8'h01);
        @(negedge clk);
        drive(64'h1011_1213_1415_1617, 3'b110, 1'b1);
        tick();
        chk("b2b2 out_q", bus.out_q, 8'h11);

        // Reset overrides in_valid; comb path stays live
        @(negedge clk);
        rst_n = 1'b0;
        drive(64'h5500_0000_0000_0000, 3'b111, 1'b1);
        tick();
        chk("rst out_q", bus.out_q, 8'h00);
        chk("rst out_valid", {7'b0, bus.out_valid}, 8'h00);
        chk("rst out live", bus.out, 8'h55);
        @(negedge clk);
        rst_n = 1'b1;
        drive(64'h0000_0000_0000_0000, 3'b010, 1'b0);
        tick();
        chk("post rst idle out_q", bus.out_q, 8'h00);
        chk("post rst idle out_valid", {7'b0, bus.out_valid}, 8'h00);
        @(negedge clk);
        drive(64'h0000_0000_003C_0000, 3'b010, 1'b1);
        tick();
        chk("first capture out_q", bus.out_q, 8'h3C);
        chk("first capture out_valid", {7'b0, bus.out_valid}, 8'h01);
`else
        drive(64'h0000_0000_0100_0000, 3'b011, 1'b1); #1;
        chk("pt out_q e", bus.out_q, 8'h01);
        chk("pt out_valid 1", {7'b0, bus.out_valid}, 8'h01);
        drive(64'hA0A1_A2A3_A4A5_A6A7, 3'b101, 1'b0); #1;
        chk("pt out_q c", bus.out_q, 8'hA2);
        chk("pt out_valid 0", {7'b0, bus.out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        drive(64'h5500_0000_0000_0000, 3'b111, 1'b1);
        tick();
        chk("pt rst out live", bus.out, 8'h55);
        chk("pt rst out_q", bus.out_q, 8'h55);
        rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
